// File: rtl/controle_mult_escalar.sv
// ---------------------------------------------------------------------------
// controle_mult_escalar
//
// Purpose:
//    Sequencer that computes nova_matriz_A = num_inteiro * matriz_A for a
//    packed 5x5 matrix of signed 8-bit elements. A single signed multiplier
//    is reused for every element, so one element is handled per clock.
//    Each product is saturated to the signed 8-bit range, and the number of
//    saturated elements is reported. The visible result register is only
//    updated when the whole matrix has been computed.
//
// Ports:
//    clk            system clock, rising edge
//    rst            asynchronous, active-high reset
//    start          request pulse, only sampled while idle
//    matriz_A       packed signed matrix, element k at [k*LARGURA +: LARGURA]
//    num_inteiro    signed scalar
//    nova_matriz_A  registered result matrix, same packing as matriz_A
//    busy           high while elements are being computed
//    done           one-cycle pulse when nova_matriz_A holds a new result
//    sat_count      number of saturated elements in the last operation
// ---------------------------------------------------------------------------
module controle_mult_escalar #(
   parameter int N_ELEM  = 25,
   parameter int LARGURA = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_ELEM*LARGURA-1:0]   matriz_A,
   input  logic [LARGURA-1:0]          num_inteiro,
   output logic [N_ELEM*LARGURA-1:0]   nova_matriz_A,
   output logic                        busy,
   output logic                        done,
   output logic [4:0]                  sat_count
);

   localparam int IDX_W  = $clog2(N_ELEM);
   localparam int MAT_W  = N_ELEM * LARGURA;
   localparam int PROD_W = 2 * LARGURA;

   localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (LARGURA - 1)) - 1);
   localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(-(1 << (LARGURA - 1)));
   localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_ELEM - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIM
   } state_t;

   state_t                     r_state;
   state_t                     w_nextState;

   logic [MAT_W-1:0]           r_matA;
   logic signed [LARGURA-1:0]  r_scalar;
   logic [MAT_W-1:0]           r_shadow;
   logic [MAT_W-1:0]           r_novaMatriz;
   logic [IDX_W-1:0]           r_idx;
   logic [4:0]                 r_satCnt;
   logic [4:0]                 r_satCount;
   logic                       r_busy;
   logic                       r_done;

   logic                       w_load;
   logic                       w_step;
   logic                       w_finish;
   logic                       w_lastIdx;
   logic signed [LARGURA-1:0]  w_elem;
   logic signed [PROD_W-1:0]   w_prod;
   logic [LARGURA-1:0]         w_satElem;
   logic                       w_isSat;
   logic [MAT_W-1:0]           w_shadowNext;
   logic [4:0]                 w_satCntNext;

   assign w_lastIdx = (r_idx == LAST_IDX);

   // Operand for the current element comes from the latched copy of the
   // input matrix, so input changes during an operation have no effect.
   assign w_elem = r_matA[int'(r_idx)*LARGURA +: LARGURA];
   assign w_prod = w_elem * r_scalar;

   // Clamp the full-width product into the signed element range; values
   // already in range survive truncation unchanged.
   always_comb begin
      w_satElem = w_prod[LARGURA-1:0];
      w_isSat   = 1'b0;
      if (w_prod > SAT_MAX) begin
         w_satElem = SAT_MAX[LARGURA-1:0];
         w_isSat   = 1'b1;
      end else if (w_prod < SAT_MIN) begin
         w_satElem = SAT_MIN[LARGURA-1:0];
         w_isSat   = 1'b1;
      end
   end

   // Shadow matrix with the current element merged in. On the last element
   // this merged value is what gets published, so the final element does
   // not need an extra cycle to land in the shadow first.
   always_comb begin
      w_shadowNext = r_shadow;
      w_shadowNext[int'(r_idx)*LARGURA +: LARGURA] = w_satElem;
      w_satCntNext = r_satCnt + 5'(w_isSat);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic plus the control strobes the datapath acts on.
   // Start is only looked at while idle; there is no request queue.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = CALC;
               w_load      = 1'b1;
            end
         end
         CALC: begin
            w_step = 1'b1;
            if (w_lastIdx) begin
               w_nextState = FIM;
               w_finish    = 1'b1;
            end
         end
         FIM: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, per-element shadow update and publication
   // of the completed result. busy and done are registered copies of the
   // upcoming state so they are glitch-free and never overlap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_matA       <= '0;
         r_scalar     <= '0;
         r_shadow     <= '0;
         r_novaMatriz <= '0;
         r_idx        <= '0;
         r_satCnt     <= '0;
         r_satCount   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_busy <= (w_nextState == CALC);
         r_done <= (w_nextState == FIM);
         if (w_load) begin
            r_matA   <= matriz_A;
            r_scalar <= num_inteiro;
            r_shadow <= '0;
            r_satCnt <= '0;
            r_idx    <= '0;
         end else if (w_step) begin
            r_shadow <= w_shadowNext;
            r_satCnt <= w_satCntNext;
            if (!w_lastIdx) begin
               r_idx <= r_idx + 1'b1;
            end
         end
         if (w_finish) begin
            r_novaMatriz <= w_shadowNext;
            r_satCount   <= w_satCntNext;
         end
      end
   end

   assign nova_matriz_A = r_novaMatriz;
   assign sat_count     = r_satCount;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_controle_mult_escalar.sv
// ---------------------------------------------------------------------------
// tb_controle_mult_escalar
//
// Purpose:
//    Self-checking bench for controle_mult_escalar. Operands are kept as
//    plain integer arrays; the expected matrix is computed with integer
//    multiplication and clamping, then packed for comparison.
// ---------------------------------------------------------------------------
module tb_controle_mult_escalar;

   logic          clk;
   logic          rst;
   logic          start;
   logic [199:0]  matriz_A;
   logic [7:0]    num_inteiro;
   logic [199:0]  nova_matriz_A;
   logic          busy;
   logic          done;
   logic [4:0]    sat_count;

   int            nChecks;
   int            nFail;

   int            tbElems [25];
   int            tbScalar;
   logic [199:0]  expMat;
   logic [4:0]    expSat;

   int            lat;
   bit            busyAtStart;
   bit            overlap;
   bit            busyGap;
   bit            doneAfter;

   controle_mult_escalar dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .matriz_A      (matriz_A),
      .num_inteiro   (num_inteiro),
      .nova_matriz_A (nova_matriz_A),
      .busy          (busy),
      .done          (done),
      .sat_count     (sat_count)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Packs the integer operand array into the DUT's bus layout.
   function automatic logic [199:0] packMat();
      logic [199:0] v;
      v = '0;
      for (int k = 0; k < 25; k++) begin
         v[k*8 +: 8] = 8'(tbElems[k]);
      end
      return v;
   endfunction

   // Reference: integer product, clamped to [-128, 127], counting clamps.
   function automatic void computeModel();
      int p;
      int cnt;
      cnt = 0;
      expMat = '0;
      for (int k = 0; k < 25; k++) begin
         p = tbElems[k] * tbScalar;
         if (p > 127) begin
            p = 127;
            cnt++;
         end else if (p < -128) begin
            p = -128;
            cnt++;
         end
         expMat[k*8 +: 8] = 8'(p);
      end
      expSat = 5'(cnt);
   endfunction

   function automatic int randElem();
      return int'($urandom_range(255)) - 128;
   endfunction

   // Launches one operation with the current tbElems/tbScalar, scrambles
   // the inputs right after acceptance, and measures latency and handshake.
   task automatic applyStimulus();
      computeModel();
      @(posedge clk);
      #1;
      matriz_A    = packMat();
      num_inteiro = 8'(tbScalar);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      matriz_A    = ~matriz_A;
      num_inteiro = ~num_inteiro;
      busyAtStart = busy;
      overlap     = 1'b0;
      busyGap     = 1'b0;
      lat         = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy && done) overlap = 1'b1;
         if (!busy && !done) busyGap = 1'b1;
      end
      @(posedge clk);
      #1;
      doneAfter = done;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      start       = 1'b0;
      matriz_A    = '0;
      num_inteiro = '0;
      repeat (3) @(posedge clk);
      #1;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done got=%b want=0", done); end
      nChecks++; if (nova_matriz_A !== 200'd0) begin nFail++; $display("[TB] FAIL reset_matrix got=%h want=0", nova_matriz_A); end
      nChecks++; if (sat_count !== 5'd0) begin nFail++; $display("[TB] FAIL reset_sat got=%0d want=0", sat_count); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_saturate_pos();
      for (int k = 0; k < 25; k++) tbElems[k] = 100;
      tbScalar = 2;
      applyStimulus();
      nChecks++; if (busyAtStart !== 1'b1) begin nFail++; $display("[TB] FAIL pos_busy_start got=%b want=1", busyAtStart); end
      nChecks++; if (lat != 25) begin nFail++; $display("[TB] FAIL pos_latency got=%0d want=25", lat); end
      nChecks++; if (overlap !== 1'b0) begin nFail++; $display("[TB] FAIL pos_busy_done_overlap got=%b want=0", overlap); end
      nChecks++; if (busyGap !== 1'b0) begin nFail++; $display("[TB] FAIL pos_busy_gap got=%b want=0", busyGap); end
      nChecks++; if (doneAfter !== 1'b0) begin nFail++; $display("[TB] FAIL pos_done_width got=%b want=0", doneAfter); end
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL pos_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (sat_count !== 5'd25) begin nFail++; $display("[TB] FAIL pos_sat got=%0d want=25", sat_count); end
   endtask

   task automatic test_saturate_neg();
      for (int k = 0; k < 25; k++) tbElems[k] = 50;
      tbScalar = -3;
      applyStimulus();
      nChecks++; if (lat != 25) begin nFail++; $display("[TB] FAIL neg_latency got=%0d want=25", lat); end
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL neg_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (sat_count !== 5'd25) begin nFail++; $display("[TB] FAIL neg_sat got=%0d want=25", sat_count); end
      for (int k = 0; k < 25; k++) tbElems[k] = 10;
      tbScalar = 5;
      applyStimulus();
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL inrange_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (sat_count !== 5'd0) begin nFail++; $display("[TB] FAIL inrange_sat got=%0d want=0", sat_count); end
   endtask

   task automatic test_mixed();
      for (int k = 0; k < 25; k++) tbElems[k] = k - 12;
      tbScalar = 10;
      applyStimulus();
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL mixed_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (nova_matriz_A[7:0] !== 8'h88) begin nFail++; $display("[TB] FAIL mixed_elem0 got=%h want=88", nova_matriz_A[7:0]); end
      nChecks++; if (nova_matriz_A[199:192] !== 8'h78) begin nFail++; $display("[TB] FAIL mixed_elem24 got=%h want=78", nova_matriz_A[199:192]); end
      nChecks++; if (sat_count !== 5'd0) begin nFail++; $display("[TB] FAIL mixed_sat got=%0d want=0", sat_count); end
   endtask

   task automatic test_edge_cases();
      tbElems[0] = -128;
      for (int k = 1; k < 25; k++) tbElems[k] = 1;
      tbScalar = -1;
      applyStimulus();
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL edge_neg1_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (nova_matriz_A[7:0] !== 8'h7F) begin nFail++; $display("[TB] FAIL edge_min_times_neg1 got=%h want=7f", nova_matriz_A[7:0]); end
      nChecks++; if (sat_count !== 5'd1) begin nFail++; $display("[TB] FAIL edge_neg1_sat got=%0d want=1", sat_count); end
      for (int k = 0; k < 25; k++) tbElems[k] = randElem();
      tbElems[0] = -128;
      tbScalar = 1;
      applyStimulus();
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL edge_one_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (nova_matriz_A[7:0] !== 8'h80) begin nFail++; $display("[TB] FAIL edge_min_times_one got=%h want=80", nova_matriz_A[7:0]); end
      nChecks++; if (sat_count !== 5'd0) begin nFail++; $display("[TB] FAIL edge_one_sat got=%0d want=0", sat_count); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < 25; k++) tbElems[k] = randElem();
         tbScalar = (t == 0) ? 0 : randElem();
         applyStimulus();
         nChecks++; if (lat != 25) begin nFail++; $display("[TB] FAIL rand%0d_latency got=%0d want=25", t, lat); end
         nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL rand%0d_matrix got=%h want=%h", t, nova_matriz_A, expMat); end
         nChecks++; if (sat_count !== expSat) begin nFail++; $display("[TB] FAIL rand%0d_sat got=%0d want=%0d", t, sat_count, expSat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [199:0] prevExp;
      int           cyc;
      bit           holdErr;
      bit           extraDone;
      prevExp = expMat;
      for (int k = 0; k < 25; k++) tbElems[k] = randElem();
      tbScalar = randElem();
      computeModel();
      @(posedge clk);
      #1;
      matriz_A    = packMat();
      num_inteiro = 8'(tbScalar);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      cyc     = 0;
      holdErr = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         start = 1'b0;
         if (!done && nova_matriz_A !== prevExp) holdErr = 1'b1;
         if (cyc == 3 || cyc == 20) begin
            start       = 1'b1;
            matriz_A    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            num_inteiro = num_inteiro + 8'd1;
         end
      end
      start = 1'b0;
      nChecks++; if (cyc != 25) begin nFail++; $display("[TB] FAIL ignore_latency got=%0d want=25", cyc); end
      nChecks++; if (holdErr !== 1'b0) begin nFail++; $display("[TB] FAIL ignore_partial_visible got=%b want=0", holdErr); end
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL ignore_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (sat_count !== expSat) begin nFail++; $display("[TB] FAIL ignore_sat got=%0d want=%0d", sat_count, expSat); end

      for (int k = 0; k < 25; k++) tbElems[k] = randElem();
      tbScalar = randElem();
      computeModel();
      @(posedge clk);
      #1;
      nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_done_drop got=%b want=0", done); end
      matriz_A    = packMat();
      num_inteiro = 8'(tbScalar);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      nChecks++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_accept got=%b want=1", busy); end
      cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      nChecks++; if (cyc != 25) begin nFail++; $display("[TB] FAIL b2b_latency got=%0d want=25", cyc); end
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL b2b_matrix got=%h want=%h", nova_matriz_A, expMat); end
      extraDone = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) extraDone = 1'b1;
      end
      nChecks++; if (extraDone !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_no_queued_op got=%b want=0", extraDone); end
   endtask

   task automatic test_reset_mid();
      bit spurious;
      for (int k = 0; k < 25; k++) tbElems[k] = randElem();
      tbScalar = randElem();
      @(posedge clk);
      #1;
      matriz_A    = packMat();
      num_inteiro = 8'(tbScalar);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
      nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
      nChecks++; if (nova_matriz_A !== 200'd0) begin nFail++; $display("[TB] FAIL midrst_matrix got=%h want=0", nova_matriz_A); end
      nChecks++; if (sat_count !== 5'd0) begin nFail++; $display("[TB] FAIL midrst_sat got=%0d want=0", sat_count); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      spurious = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) spurious = 1'b1;
      end
      nChecks++; if (spurious !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_no_done got=%b want=0", spurious); end
      for (int k = 0; k < 25; k++) tbElems[k] = 1;
      tbScalar = 0;
      applyStimulus();
      nChecks++; if (lat != 25) begin nFail++; $display("[TB] FAIL after_rst_latency got=%0d want=25", lat); end
      nChecks++; if (nova_matriz_A !== expMat) begin nFail++; $display("[TB] FAIL after_rst_matrix got=%h want=%h", nova_matriz_A, expMat); end
      nChecks++; if (sat_count !== 5'd0) begin nFail++; $display("[TB] FAIL after_rst_sat got=%0d want=0", sat_count); end
   endtask

   // Runs every scenario in order, then reports totals.
   initial begin
      nChecks = 0;
      nFail   = 0;
      test_reset();
      test_saturate_pos();
      test_saturate_neg();
      test_mixed();
      test_edge_cases();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end

endmodule
